// File: rtl/out_stream_framer.sv
// Frames a merged AXI-Stream into programmed-length bursts with tlast, done and busy.
// Optional OUT_FRAMER_STAT_EN adds a stall_cnt port counting output back-pressure cycles.
//
// state | meaning
// IDLE  | waiting for start; no beats accepted
// RUN   | accepting input beats until len have been taken
// DRAIN | input closed; emptying buffer until the tlast handshake
module out_stream_framer #(
  parameter int DWIDTH    = 128,
  parameter int LEN_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [LEN_WIDTH-1:0] frame_len,
  input  logic [DWIDTH-1:0]    s_axis_tdata,
  input  logic                 s_axis_tvalid,
  output logic                 s_axis_tready,
  output logic [DWIDTH-1:0]    m_axis_tdata,
  output logic                 m_axis_tvalid,
  input  logic                 m_axis_tready,
  output logic                 m_axis_tlast,
  output logic                 busy,
  output logic                 done
`ifdef OUT_FRAMER_STAT_EN
  ,
  output logic [31:0]          stall_cnt
`endif
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  localparam logic [LEN_WIDTH-1:0] ONE = LEN_WIDTH'(1);

  state_t               state, state_nxt;
  logic [LEN_WIDTH-1:0] len_q, in_cnt, out_cnt;
  logic [DWIDTH-1:0]    out_data, skid_data;
  logic                 out_valid, skid_valid;
  logic                 done_q, done_nxt;
  logic                 accept, drain, last_hs, start_run;

  assign s_axis_tready = (state == RUN) && !skid_valid && (in_cnt < len_q);
  assign accept        = s_axis_tvalid && s_axis_tready;
  assign drain         = out_valid && m_axis_tready;
  assign m_axis_tvalid = out_valid;
  assign m_axis_tdata  = out_data;
  // Beats leave in acceptance order, so the output index alone identifies the last beat.
  assign m_axis_tlast  = out_valid && (out_cnt == len_q - ONE);
  assign last_hs       = drain && m_axis_tlast;
  assign busy          = (state != IDLE);
  assign done          = done_q;
  assign start_run     = (state == IDLE) && start && (frame_len != '0);

  always_comb begin
    state_nxt = state;
    done_nxt  = 1'b0;
    unique case (state)
      IDLE: begin
        if (start && frame_len == '0) done_nxt = 1'b1;
        else if (start) state_nxt = RUN;
      end
      RUN: begin
        if (accept && in_cnt == len_q - ONE) state_nxt = DRAIN;
      end
      DRAIN: begin
        if (last_hs) begin
          state_nxt = IDLE;
          done_nxt  = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= IDLE;
      done_q <= 1'b0;
    end else begin
      state  <= state_nxt;
      done_q <= done_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      len_q   <= '0;
      in_cnt  <= '0;
      out_cnt <= '0;
    end else if (start_run) begin
      len_q   <= frame_len;
      in_cnt  <= '0;
      out_cnt <= '0;
    end else begin
      if (accept) in_cnt  <= in_cnt + ONE;
      if (drain)  out_cnt <= out_cnt + ONE;
    end
  end

  // Two-entry pipeline: the output register refills from skid first, then from the input.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid  <= 1'b0;
      out_data   <= '0;
      skid_valid <= 1'b0;
      skid_data  <= '0;
    end else if (drain || !out_valid) begin
      if (skid_valid) begin
        out_valid  <= 1'b1;
        out_data   <= skid_data;
        skid_valid <= 1'b0;
      end else if (accept) begin
        out_valid <= 1'b1;
        out_data  <= s_axis_tdata;
      end else begin
        out_valid <= 1'b0;
      end
    end else if (accept) begin
      skid_valid <= 1'b1;
      skid_data  <= s_axis_tdata;
    end
  end

`ifdef OUT_FRAMER_STAT_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_cnt <= '0;
    end else if (state == IDLE && start) begin
      stall_cnt <= '0;
    end else if (out_valid && !m_axis_tready && stall_cnt != 32'hFFFF_FFFF) begin
      stall_cnt <= stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: doc/out_stream_framer.md
Name: out_stream_framer

Overview:
Downstream stage of the two-input output switch. Consumes its merged DWIDTH-bit AXI-Stream result and cuts it into frames of a programmed beat count. Asserts tlast on the final beat of each frame. Provides a registered, full-throughput, back-pressure-safe output to the DMA/DDR write path, plus busy/done status for the layer controller.

Parameters:
DWIDTH, 128, data width of input and output streams
LEN_WIDTH, 16, width of frame length (beats) and internal beat counters

Ports:
clk  input  1  clock
rst_n  input  1  reset, synchronous, active-low
start  input  1  single-cycle pulse; begins a frame; honoured only in IDLE
frame_len  input  LEN_WIDTH  beats per frame; sampled on accepted start
s_axis_tdata  input  DWIDTH  input data from switch
s_axis_tvalid  input  1  input valid
s_axis_tready  output  1  input ready
m_axis_tdata  output  DWIDTH  output data
m_axis_tvalid  output  1  output valid
m_axis_tready  input  1  output ready
m_axis_tlast  output  1  last beat of frame
busy  output  1  high in RUN or DRAIN
done  output  1  one-cycle pulse at frame completion

Behaviour:
- Reset (rst_n=0 at posedge):
  - state=IDLE; all counters 0; both buffer entries invalid.
  - Outputs: s_axis_tready=0, m_axis_tvalid=0, m_axis_tlast=0, m_axis_tdata=0, busy=0, done=0.
  - Reset mid-frame discards buffered beats; no done pulse is issued.
- FSM states: IDLE, RUN, DRAIN.
  - IDLE, start=1, frame_len!=0: latch len=frame_len; clear in_cnt and out_cnt; go to RUN.
  - IDLE, start=1, frame_len==0: done=1 on next cycle; stay in IDLE; no beats accepted or emitted.
  - RUN: accept beats. When the accepted beat makes in_cnt==len, go to DRAIN the following cycle.
  - DRAIN: s_axis_tready=0. When the tlast beat handshakes at the output, pulse done=1 on the next cycle and return to IDLE.
  - start in RUN or DRAIN is ignored; frame_len changes are ignored until the next accepted start.
- Input handshake:
  - Accept = s_axis_tvalid & s_axis_tready.
  - s_axis_tready = (state==RUN) & ~skid_valid & (in_cnt<len), driven from registers only.
  - Input is never accepted past len beats.
- Buffering: 2-entry pipeline made of an output register and a skid register.
  - Accepted beat goes to the output register if it is empty or draining this cycle; otherwise it goes to the skid register.
  - When the output drains and skid is valid, skid moves to the output register.
  - Latency from input accept to m_axis_tvalid is 1 cycle.
  - Sustained throughput is 1 beat/cycle while m_axis_tready=1.
  - No beat is lost or duplicated under any tready pattern.
- Output handshake:
  - m_axis_tvalid, m_axis_tdata and m_axis_tlast stay stable while tvalid=1 and tready=0.
  - out_cnt increments on each output handshake.
  - m_axis_tlast=1 exactly on the beat whose index is len-1.
- Counters: in_cnt and out_cnt are LEN_WIDTH bits. Maximum frame is 2^LEN_WIDTH-1 beats; no wrap within a frame.
- busy: registered; =1 from the cycle after an accepted start through the cycle the tlast handshake occurs.
- Simultaneous accept at input and drain at output in the same cycle: buffer occupancy is unchanged.

Optional Feature:
OUT_FRAMER_STAT_EN
- Defined: adds output port stall_cnt [31:0].
  - Counts cycles where m_axis_tvalid=1 and m_axis_tready=0 during the frame.
  - Clears to 0 on accepted start; holds its value after done.
  - Saturates at 0xFFFFFFFF; reset value 0.
- Undefined: the port and counter are absent; all other behaviour is identical.

Test Plan:
- start with frame_len=4, s_tvalid and m_tready held 1 with data 1..4 -> m_tvalid 1 cycle after first accept; 4 consecutive beats 1..4; tlast on beat 4; done pulses 1 cycle after; busy=0 afterwards.
- frame_len=8, m_tready=0 for 3 cycles after beat 2 -> s_tready drops after 2 beats are buffered; output sequence 1..8 intact with no gap once ready returns; tlast on 8; (stat) stall_cnt=3.
- start with frame_len=0 -> done=1 next cycle; m_tvalid, busy and s_tready stay 0.
- frame_len=1 -> exactly one beat, with tlast=1 on it; a 2nd valid input beat is not accepted (s_tready=0).
- start pulsed again mid-frame with frame_len=2, running frame_len=5 -> pulse ignored; 5 beats emitted; tlast on the 5th.
- rst_n=0 for 1 cycle after 3 of 6 beats -> all outputs 0 next cycle and state=IDLE; no done; a fresh start with len=2 runs correctly.
